// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port (1W/1R) byte-enable RAM with power-up clear engine.
// Optional feature: define RAM_DP_PARITY_EN to store one even-parity bit per
// byte lane and flag mismatches on read (rd_perr). Without it rd_perr is 0.
module ram_dp_be #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned NBYTE  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              ready,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [NBYTE-1:0]  wr_be,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_perr_inj,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_perr
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   logic              wr_acc;
   logic              rd_acc;

   // Shared array write port, driven either by the clear engine or the user.
   logic [NBYTE-1:0]  mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_merged;

   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   assign ready  = (state_q == ST_IDLE);
   assign wr_acc = wr_en & ready;
   assign rd_acc = rd_en & ready;

   // Controller next state: walk every address once in CLEAR, then idle.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == '1) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Write port select: clear engine owns the array while not ready.
   always_comb begin
      mem_we    = '0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (state_q == ST_CLEAR) begin
         mem_we    = '1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end else if (wr_acc) begin
         mem_we    = wr_be;
      end
   end

   // Data array: no reset, zeroed only by the clear engine.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NBYTE; i++) begin
         if (mem_we[i]) begin
            mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   assign rd_word = mem_q[rd_addr];

   // Write-first merge: lanes written this cycle to the read address bypass the array.
   always_comb begin
      rd_merged = rd_word;
      for (int unsigned i = 0; i < NBYTE; i++) begin
         if (wr_acc && (wr_addr == rd_addr) && wr_be[i]) begin
            rd_merged[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
   end

   // Read output next values; rd_data holds when no read is accepted.
   always_comb begin
      rd_valid_d = rd_acc;
      rd_data_d  = rd_acc ? rd_merged : rd_data_q;
   end

   // Read output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

`ifdef RAM_DP_PARITY_EN
   logic [NBYTE-1:0] mem_wpar;
   logic [NBYTE-1:0] wr_par;
   logic [NBYTE-1:0] par_q [DEPTH];
   logic [NBYTE-1:0] rd_par_merged;
   logic             rd_perr_q, rd_perr_d;

   // Even parity per lane, optionally inverted to inject an error.
   always_comb begin
      wr_par = '0;
      for (int unsigned i = 0; i < NBYTE; i++) begin
         wr_par[i] = (^wr_data[8*i +: 8]) ^ wr_perr_inj;
      end
      mem_wpar = (state_q == ST_CLEAR) ? '0 : wr_par;
   end

   // Parity array, written alongside the data lanes.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NBYTE; i++) begin
         if (mem_we[i]) begin
            par_q[mem_waddr][i] <= mem_wpar[i];
         end
      end
   end

   // Parity check on the merged word; forwarded lanes use the parity being written.
   always_comb begin
      rd_par_merged = par_q[rd_addr];
      for (int unsigned i = 0; i < NBYTE; i++) begin
         if (wr_acc && (wr_addr == rd_addr) && wr_be[i]) begin
            rd_par_merged[i] = wr_par[i];
         end
      end
      rd_perr_d = 1'b0;
      if (rd_acc) begin
         for (int unsigned i = 0; i < NBYTE; i++) begin
            if ((^rd_merged[8*i +: 8]) != rd_par_merged[i]) begin
               rd_perr_d = 1'b1;
            end
         end
      end
   end

   // Parity error flag register, aligned with rd_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_perr_q <= 1'b0;
      end else begin
         rd_perr_q <= rd_perr_d;
      end
   end

   assign rd_perr = rd_perr_q;
`else
   logic unused_perr_inj;
   assign unused_perr_inj = wr_perr_inj;
   assign rd_perr         = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: directed self-checking bench for ram_dp_be (DATA_W=32, ADDR_W=4).
// Parity expectations follow RAM_DP_PARITY_EN when it is defined.
module tb_ram_dp_be;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned NBYTE  = DATA_W / 8;

`ifdef RAM_DP_PARITY_EN
   localparam logic PINJ = 1'b1;
`else
   localparam logic PINJ = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              clr_req;
   logic              ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [NBYTE-1:0]  wr_be;
   logic [DATA_W-1:0] wr_data;
   logic              wr_perr_inj;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_perr;

   int n_checks = 0;
   int n_errors = 0;
   int n_cyc;

   ram_dp_be #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req    (clr_req),
      .ready      (ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_be      (wr_be),
      .wr_data    (wr_data),
      .wr_perr_inj(wr_perr_inj),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_perr    (rd_perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Count negedges until ready is seen, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [NBYTE-1:0] be,
                     input logic [DATA_W-1:0] d, input logic inj);
      wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d; wr_perr_inj = inj;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0; wr_perr_inj = 1'b0;
   endtask

   // Read, check the beat, then check the pulse ends and data holds.
   task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] exp_d, input logic exp_p);
      rd_en = 1'b1; rd_addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      chk({tag, ".valid"}, 32'(rd_valid), 32'd1);
      chk({tag, ".data"},  rd_data, exp_d);
      chk({tag, ".perr"},  32'(rd_perr), 32'(exp_p));
      @(negedge clk);
      chk({tag, ".valid_end"}, 32'(rd_valid), 32'd0);
      chk({tag, ".hold"},      rd_data, exp_d);
   endtask

   initial begin
      rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0;
      wr_data = '0; wr_perr_inj = 1'b0; rd_en = 1'b0; rd_addr = '0;
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(ready), 32'd0);
      chk("rst.valid", 32'(rd_valid), 32'd0);
      chk("rst.data",  rd_data, 32'd0);
      chk("rst.perr",  32'(rd_perr), 32'd0);

      // Power-up clear: 16 cycles, then a read in the first ready cycle.
      rst_n = 1'b1;
      wait_ready(n_cyc);
      chk("clr0.cycles", 32'(n_cyc), 32'd16);
      rd_chk("first_idle_rd", 4'd9, 32'h0000_0000, 1'b0);

      // Byte-enable merge.
      wr(4'd3, 4'b1111, 32'hAABB_CCDD, 1'b0);
      wr(4'd3, 4'b0101, 32'h1122_3344, 1'b0);
      rd_chk("be_merge", 4'd3, 32'hAA22_CC44, 1'b0);
      wr(4'd3, 4'b0000, 32'hFFFF_FFFF, 1'b0);
      rd_chk("be_zero", 4'd3, 32'hAA22_CC44, 1'b0);

      // Same-address write-first forwarding.
      wr(4'd5, 4'b1111, 32'h1234_5678, 1'b0);
      wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b0011; wr_data = 32'hDEAD_BEEF;
      rd_en = 1'b1; rd_addr = 4'd5;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
      chk("fwd.valid", 32'(rd_valid), 32'd1);
      chk("fwd.data",  rd_data, 32'h1234_BEEF);
      rd_chk("fwd_stored", 4'd5, 32'h1234_BEEF, 1'b0);

      // Different-address write and read in the same cycle.
      wr_en = 1'b1; wr_addr = 4'd6; wr_be = 4'b1111; wr_data = 32'hCAFE_F00D;
      rd_en = 1'b1; rd_addr = 4'd3;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
      chk("dual.valid", 32'(rd_valid), 32'd1);
      chk("dual.data",  rd_data, 32'hAA22_CC44);
      rd_chk("dual_wr", 4'd6, 32'hCAFE_F00D, 1'b0);

      // clr_req: requests during CLEAR dropped, repeat clr_req ignored.
      wr(4'd7, 4'b1111, 32'hFFFF_FFFF, 1'b0);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      chk("clr1.ready", 32'(ready), 32'd0);
      rd_en = 1'b1; rd_addr = 4'd7; clr_req = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; clr_req = 1'b0;
      chk("clr1.rd_drop", 32'(rd_valid), 32'd0);
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd0; wr_be = 4'b1111; wr_data = 32'h5555_5555;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0;
      n_cyc = 5;
      while (!ready && n_cyc < 40) begin
         @(negedge clk);
         n_cyc++;
      end
      chk("clr1.cycles", 32'(n_cyc), 32'd16);
      rd_chk("clr1_addr7", 4'd7, 32'h0000_0000, 1'b0);
      rd_chk("clr1_wr_drop", 4'd0, 32'h0000_0000, 1'b0);

      // Reset at clr_cnt = 9 restarts the clear.
      wr(4'd10, 4'b1111, 32'h1212_1212, 1'b0);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst9.ready", 32'(ready), 32'd0);
      repeat (2) @(negedge clk);
      chk("rst9.ready_hold", 32'(ready), 32'd0);
      rst_n = 1'b1;
      wait_ready(n_cyc);
      chk("rst9.cycles", 32'(n_cyc), 32'd16);
      rd_chk("rst9_addr10", 4'd10, 32'h0000_0000, 1'b0);

      // Reset before the edge that would accept a read aborts it.
      wr(4'd4, 4'b1111, 32'h0BAD_F00D, 1'b0);
      rd_en = 1'b1; rd_addr = 4'd4;
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      rd_en = 1'b0;
      chk("rdabort.valid", 32'(rd_valid), 32'd0);
      chk("rdabort.data",  rd_data, 32'd0);
      rst_n = 1'b1;
      wait_ready(n_cyc);
      chk("rdabort.cycles", 32'(n_cyc), 32'd16);

      // Parity injection (ignored when the parity feature is absent).
      wr(4'd2, 4'b1111, 32'h0102_0304, 1'b1);
      rd_chk("par_inj", 4'd2, 32'h0102_0304, PINJ);
      wr(4'd2, 4'b1111, 32'h0102_0304, 1'b0);
      rd_chk("par_clean", 4'd2, 32'h0102_0304, 1'b0);
      wr_en = 1'b1; wr_addr = 4'd2; wr_be = 4'b0001; wr_data = 32'h0000_00FF;
      wr_perr_inj = 1'b1; rd_en = 1'b1; rd_addr = 4'd2;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0; wr_perr_inj = 1'b0; rd_en = 1'b0;
      chk("par_fwd.data", rd_data, 32'h0102_03FF);
      chk("par_fwd.perr", 32'(rd_perr), 32'(PINJ));
      rd_chk("par_fwd_stored", 4'd2, 32'h0102_03FF, PINJ);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
